// File: rtl/systolic_skew_feeder_if.sv
// -----------------------------------------------------------------------------
// systolic_skew_feeder_if
//   Operand stream between an upstream producer and the systolic skew feeder.
//   One beat carries a whole reduction step: ROWS fmap values plus COLS weights.
//
//   s_valid   producer -> feeder   beat valid
//   s_ready   feeder   -> producer feeder accepts beat
//   s_fmap    producer -> feeder   fmap row r at [(r+1)*I_F_BW-1 -: I_F_BW]
//   s_weight  producer -> feeder   weight col c at [(c+1)*W_BW-1 -: W_BW]
//
//   master : producer side
//   slave  : feeder side
// -----------------------------------------------------------------------------
interface systolic_skew_feeder_if #(
   parameter int I_F_BW = 8,
   parameter int W_BW   = 8,
   parameter int ROWS   = 5,
   parameter int COLS   = 5
);
   logic                     s_valid;
   logic                     s_ready;
   logic [I_F_BW*ROWS-1:0]   s_fmap;
   logic [W_BW*COLS-1:0]     s_weight;

   modport master (output s_valid, output s_fmap, output s_weight, input s_ready);
   modport slave  (input s_valid, input s_fmap, input s_weight, output s_ready);
endinterface

// File: rtl/systolic_skew_feeder.sv
// -----------------------------------------------------------------------------
// systolic_skew_feeder
//   Operand feeder and sequencer for a ROWS x COLS systolic MAC array.
//   Accepts one flat beat per reduction step, skews it diagonally onto the
//   array's west (fmap) and north (weight) edges, and generates the per-
//   diagonal MAC enables, per-row store pulses and per-PE clock-gate enables.
//   One job of k_len steps runs per start command; done pulses at job end.
//
//   Ports
//     clk, rst   clock (rising edge), synchronous active-high reset
//     start      start pulse, honoured only in IDLE with 1 <= k_len <= K_MAX
//     k_len      reduction length, latched on an honoured start
//     busy       high in FEED and DRAIN
//     done       one-cycle pulse when the last row has stored its result
//     s          operand stream (slave side of systolic_skew_feeder_if)
//     o_fmap     skewed west-edge fmap, row r at [(r+1)*I_F_BW-1 -: I_F_BW]
//     o_weight   skewed north-edge weights, col c at [(c+1)*W_BW-1 -: W_BW]
//     mul_en     per-diagonal MAC enable, bit d covers PEs with r+c == d
//     str_en     per-row result store pulse
//     pe_en      per-PE clock-gate enable, bit r*COLS+c
//
//   Build option
//     SKEW_HOLD_EN  defined: skew registers hold their value on invalid slots
//                   (less toggling). Undefined (default): invalid slots load 0.
// -----------------------------------------------------------------------------
module systolic_skew_feeder #(
   parameter int I_F_BW = 8,
   parameter int W_BW   = 8,
   parameter int ROWS   = 5,
   parameter int COLS   = 5,
   parameter int K_MAX  = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [$clog2(K_MAX+1)-1:0]    k_len,
   output logic                          busy,
   output logic                          done,
   systolic_skew_feeder_if.slave         s,
   output logic [I_F_BW*ROWS-1:0]        o_fmap,
   output logic [W_BW*COLS-1:0]          o_weight,
   output logic [ROWS+COLS-2:0]          mul_en,
   output logic [ROWS-1:0]               str_en,
   output logic [ROWS*COLS-1:0]          pe_en
);
   localparam int KW = $clog2(K_MAX+1);
   localparam int ND = ROWS + COLS - 1;   // number of diagonals

   typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

   state_t          state, state_nxt;
   logic [KW-1:0]   k_len_q;
   logic [KW-1:0]   k_cnt;
   logic            start_ok;
   logic            accept;
   logic            last;
   logic [ND-1:0]   vsr;                  // slot-valid per diagonal
   logic [ND:0]     lsr;                  // last-beat tag, one stage longer than vsr

   assign accept = s.s_valid & s.s_ready;
   assign last   = accept && (k_cnt + 1'b1 == k_len_q);

   // ---------------------------------------------------------------- FSM
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // the pre-edge values of the others; blocking here would create ordering
   // dependent shift chains.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every output of this block is defaulted first, so no path through
   // the case leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      start_ok  = 1'b0;
      s.s_ready = 1'b0;
      busy      = 1'b0;
      unique case (state)
         IDLE: begin
            start_ok = start && (k_len != '0) && (k_len <= KW'(K_MAX));
            if (start_ok) state_nxt = FEED;
         end
         FEED: begin
            s.s_ready = 1'b1;
            busy      = 1'b1;
            if (last) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ------------------------------------------------- job length / counter
   always_ff @(posedge clk) begin
      if (rst) begin
         k_len_q <= '0;
         k_cnt   <= '0;
      end else if (start_ok) begin
         k_len_q <= k_len;
         k_cnt   <= '0;
      end else if (accept) begin
         k_cnt   <= k_cnt + 1'b1;
      end
   end

   // -------------------------------------------- valid / last shift lines
   always_ff @(posedge clk) begin
      if (rst) begin
         vsr <= '0;
         lsr <= '0;
      end else begin
         vsr <= {vsr[ND-2:0], accept};
         lsr <= {lsr[ND-1:0], last};
      end
   end

   assign mul_en = vsr;

   // lsr[r+COLS] is lsr stage r+COLS-1 delayed once: the cycle after row r's
   // final MAC on its east-most PE.
   for (genvar r = 0; r < ROWS; r++) begin : g_str
      assign str_en[r] = lsr[r+COLS];
   end

   assign done = str_en[ROWS-1];

   for (genvar r = 0; r < ROWS; r++) begin : g_pe_r
      for (genvar c = 0; c < COLS; c++) begin : g_pe_c
         assign pe_en[r*COLS+c] = vsr[r+c] | str_en[r];
      end
   end

   // ------------------------------------------------------- skew lines
   // Stage 0 is the input register shared by all lanes; row r (col c) adds r
   // (c) further stages. Stage j of a lane is aligned with vsr[j], so the
   // slot entering stage j is valid when vsr[j-1] is set.
   for (genvar r = 0; r < ROWS; r++) begin : g_frow
      logic [I_F_BW-1:0] stg [0:r];

      // NOTE: the skew stages are reset explicitly so a job starts from a
      // known all-zero edge; they are few registers, not a RAM.
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int j = 0; j <= r; j++) stg[j] <= '0;
         end else begin
`ifdef SKEW_HOLD_EN
            if (accept) stg[0] <= s.s_fmap[(r+1)*I_F_BW-1 -: I_F_BW];
            for (int j = 1; j <= r; j++)
               if (vsr[j-1]) stg[j] <= stg[j-1];
`else
            stg[0] <= accept ? s.s_fmap[(r+1)*I_F_BW-1 -: I_F_BW] : '0;
            for (int j = 1; j <= r; j++) stg[j] <= stg[j-1];
`endif
         end
      end

      assign o_fmap[(r+1)*I_F_BW-1 -: I_F_BW] = stg[r];
   end

   for (genvar c = 0; c < COLS; c++) begin : g_wcol
      logic [W_BW-1:0] stg [0:c];

      always_ff @(posedge clk) begin
         if (rst) begin
            for (int j = 0; j <= c; j++) stg[j] <= '0;
         end else begin
`ifdef SKEW_HOLD_EN
            if (accept) stg[0] <= s.s_weight[(c+1)*W_BW-1 -: W_BW];
            for (int j = 1; j <= c; j++)
               if (vsr[j-1]) stg[j] <= stg[j-1];
`else
            stg[0] <= accept ? s.s_weight[(c+1)*W_BW-1 -: W_BW] : '0;
            for (int j = 1; j <= c; j++) stg[j] <= stg[j-1];
`endif
         end
      end

      assign o_weight[(c+1)*W_BW-1 -: W_BW] = stg[c];
   end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_skew_feeder
//   Directed bench for systolic_skew_feeder (default build). A per-cycle vector
//   table covers the basic k_len=3 job; hand-written sequences cover bubbles,
//   illegal starts, reset mid-job, pe_en and back-to-back K_MAX jobs with a
//   small array model accumulating results against a golden matmul.
// -----------------------------------------------------------------------------
module tb_systolic_skew_feeder;
   localparam int I_F_BW = 8;
   localparam int W_BW   = 8;
   localparam int ROWS   = 5;
   localparam int COLS   = 5;
   localparam int K_MAX  = 16;
   localparam int KW     = $clog2(K_MAX+1);
   localparam int ND     = ROWS + COLS - 1;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     start;
   logic [KW-1:0]            k_len;
   logic                     busy, done;
   logic [I_F_BW*ROWS-1:0]   o_fmap;
   logic [W_BW*COLS-1:0]     o_weight;
   logic [ND-1:0]            mul_en;
   logic [ROWS-1:0]          str_en;
   logic [ROWS*COLS-1:0]     pe_en;

   systolic_skew_feeder_if #(.I_F_BW(I_F_BW), .W_BW(W_BW), .ROWS(ROWS), .COLS(COLS)) s_if ();

   systolic_skew_feeder #(
      .I_F_BW(I_F_BW), .W_BW(W_BW), .ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy), .done(done),
      .s(s_if), .o_fmap(o_fmap), .o_weight(o_weight), .mul_en(mul_en),
      .str_en(str_en), .pe_en(pe_en)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // ------------------------------------------------------------ array model
   // PE(r,c) sees west-edge row r delayed c cycles and north-edge col c delayed
   // r cycles, and accumulates when its diagonal's mul_en is high.
   logic [7:0]  fh  [ROWS][COLS];
   logic [7:0]  wh  [COLS][ROWS];
   int unsigned acc [ROWS][COLS];

   task automatic clear_acc();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) acc[r][c] = 0;
   endtask

   // Wait to the sampling point of the current cycle and update the model.
   task automatic sample();
      @(negedge clk);
      for (int r = 0; r < ROWS; r++) begin
         for (int j = COLS-1; j > 0; j--) fh[r][j] = fh[r][j-1];
         fh[r][0] = o_fmap[r*8 +: 8];
      end
      for (int c = 0; c < COLS; c++) begin
         for (int j = ROWS-1; j > 0; j--) wh[c][j] = wh[c][j-1];
         wh[c][0] = o_weight[c*8 +: 8];
      end
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (mul_en[r+c]) acc[r][c] += fh[r][c] * wh[c][r];
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; k_len = '0;
      s_if.s_valid = 1'b0; s_if.s_fmap = '0; s_if.s_weight = '0;
      nxt(); nxt();
      rst = 1'b0;
   endtask

   function automatic logic [7:0] fm(input int k, input int r, input int seed);
      return 8'((k + seed) * 7 + r * 3 + 1);
   endfunction

   function automatic logic [7:0] wt(input int k, input int c, input int seed);
      return 8'((k + seed) * 5 + c * 11 + 2);
   endfunction

   task automatic drive_beat(input int k, input int seed);
      for (int r = 0; r < ROWS; r++) s_if.s_fmap[r*8 +: 8] = fm(k, r, seed);
      for (int c = 0; c < COLS; c++) s_if.s_weight[c*8 +: 8] = wt(k, c, seed);
   endtask

   task automatic check_matmul(input int kl, input int seed, input string tag);
      int unsigned g;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) begin
            g = 0;
            for (int k = 0; k < kl; k++) g += fm(k, r, seed) * wt(k, c, seed);
            check($sformatf("%s_pe%0d%0d", tag, r, c), 64'(acc[r][c]), 64'(g));
         end
   endtask

   // Runs one gap-free job starting in the current cycle; returns at the
   // cycle after done (relative cycle numbers, start cycle = 0).
   task automatic run_job(input int kl, input int seed,
                          output int done_at, output int first_mul, output int last_mul);
      int bi;
      bit fin;
      bi = 0; fin = 1'b0;
      done_at = -1; first_mul = -1; last_mul = -1;
      clear_acc();
      for (int t = 0; t < 100 && !fin; t++) begin
         start = (t == 0);
         k_len = KW'(kl);
         s_if.s_valid = 1'b1;
         drive_beat(bi, seed);
         sample();
         if (mul_en != '0) begin
            if (first_mul < 0) first_mul = t;
            last_mul = t;
         end
         if (s_if.s_ready) bi++;
         if (done) begin
            done_at = t;
            fin = 1'b1;
         end
         nxt();
      end
      start = 1'b0;
      s_if.s_valid = 1'b0;
      check("job_done_within_bound", 64'(fin), 64'd1);
   endtask

   // ------------------------------------------------------- vector table
   typedef struct {
      logic          start;
      logic [KW-1:0] k_len;
      logic          s_valid;
      logic          busy;
      logic          s_ready;
      logic          done;
      logic [ND-1:0] mul_en;
      logic [4:0]    str_en;
      logic [7:0]    f4;      // o_fmap row 4
      logic [7:0]    w0;      // o_weight col 0
   } vec_t;

   vec_t tv [15];

   initial begin
      int d1, f1, l1, d2, f2, l2;
      bit seen_busy, seen_done;
      logic [ROWS*COLS-1:0] pe_exp;

      // k_len=3 job, start at cycle 0, extra starts (k_len=7) while busy.
      tv[0]  = '{1, 3, 1, 0, 0, 0, 9'h000, 5'h00, 8'h00, 8'h00};
      tv[1]  = '{0, 0, 1, 1, 1, 0, 9'h000, 5'h00, 8'h00, 8'h00};
      tv[2]  = '{1, 7, 1, 1, 1, 0, 9'h001, 5'h00, 8'h00, 8'h20};
      tv[3]  = '{0, 0, 1, 1, 1, 0, 9'h003, 5'h00, 8'h00, 8'h20};
      tv[4]  = '{0, 0, 1, 1, 0, 0, 9'h007, 5'h00, 8'h00, 8'h20};
      tv[5]  = '{1, 7, 1, 1, 0, 0, 9'h00E, 5'h00, 8'h00, 8'h00};
      tv[6]  = '{0, 0, 1, 1, 0, 0, 9'h01C, 5'h00, 8'h14, 8'h00};
      tv[7]  = '{0, 0, 1, 1, 0, 0, 9'h038, 5'h00, 8'h14, 8'h00};
      tv[8]  = '{0, 0, 1, 1, 0, 0, 9'h070, 5'h00, 8'h14, 8'h00};
      tv[9]  = '{0, 0, 1, 1, 0, 0, 9'h0E0, 5'h01, 8'h00, 8'h00};
      tv[10] = '{0, 0, 1, 1, 0, 0, 9'h1C0, 5'h02, 8'h00, 8'h00};
      tv[11] = '{0, 0, 1, 1, 0, 0, 9'h180, 5'h04, 8'h00, 8'h00};
      tv[12] = '{0, 0, 1, 1, 0, 0, 9'h100, 5'h08, 8'h00, 8'h00};
      tv[13] = '{0, 0, 1, 1, 0, 1, 9'h000, 5'h10, 8'h00, 8'h00};
      tv[14] = '{0, 0, 1, 0, 0, 0, 9'h000, 5'h00, 8'h00, 8'h00};

      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) begin
            fh[r][c] = '0;
            wh[c][r] = '0;
         end
      clear_acc();

      // ---- reset state
      do_reset();
      sample();
      check("rst_busy", 64'(busy), 0);
      check("rst_ready", 64'(s_if.s_ready), 0);
      check("rst_outs", 64'({done, mul_en, str_en, pe_en}), 0);
      check("rst_lanes", 64'({o_fmap, o_weight}), 0);
      nxt();

      // ---- table-driven k_len=3 job
      for (int r = 0; r < ROWS; r++) s_if.s_fmap[r*8 +: 8] = 8'(8'h10 + r);
      for (int c = 0; c < COLS; c++) s_if.s_weight[c*8 +: 8] = 8'(8'h20 + c);
      clear_acc();
      for (int i = 0; i < 15; i++) begin
         start = tv[i].start; k_len = tv[i].k_len; s_if.s_valid = tv[i].s_valid;
         sample();
         check($sformatf("tv%0d_busy", i),  64'(busy),            64'(tv[i].busy));
         check($sformatf("tv%0d_ready", i), 64'(s_if.s_ready),    64'(tv[i].s_ready));
         check($sformatf("tv%0d_done", i),  64'(done),            64'(tv[i].done));
         check($sformatf("tv%0d_mul", i),   64'(mul_en),          64'(tv[i].mul_en));
         check($sformatf("tv%0d_str", i),   64'(str_en),          64'(tv[i].str_en));
         check($sformatf("tv%0d_f4", i),    64'(o_fmap[39:32]),   64'(tv[i].f4));
         check($sformatf("tv%0d_w0", i),    64'(o_weight[7:0]),   64'(tv[i].w0));
         nxt();
      end
      // Every PE saw 3 identical products.
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            check($sformatf("tv_pe%0d%0d", r, c), 64'(acc[r][c]), 64'(3 * (16 + r) * (32 + c)));
      start = 1'b0; s_if.s_valid = 1'b0;

      // ---- bubble: k_len=2, beats at cycles 1 and 4, junk data when invalid
      do_reset();
      for (int t = 0; t < 16; t++) begin
         start = (t == 0); k_len = 2;
         s_if.s_valid = (t == 1 || t == 4);
         s_if.s_fmap   = (t == 1) ? {ROWS{8'hA0}} : (t == 4) ? {ROWS{8'hB0}} : {ROWS{8'hEE}};
         s_if.s_weight = (t == 1) ? {COLS{8'hC0}} : (t == 4) ? {COLS{8'hD0}} : {COLS{8'hEE}};
         sample();
         check($sformatf("bub%0d_mul0", t), 64'(mul_en[0]), 64'(t == 2 || t == 5));
         check($sformatf("bub%0d_f0", t), 64'(o_fmap[7:0]),
               (t == 2) ? 64'hA0 : (t == 5) ? 64'hB0 : 64'h0);
         check($sformatf("bub%0d_w0", t), 64'(o_weight[7:0]),
               (t == 2) ? 64'hC0 : (t == 5) ? 64'hD0 : 64'h0);
         check($sformatf("bub%0d_done", t), 64'(done), 64'(t == 14));
         check($sformatf("bub%0d_busy", t), 64'(busy), 64'(t >= 1 && t <= 14));
         nxt();
      end

      // ---- illegal starts: k_len=0 and k_len=K_MAX+1
      for (int v = 0; v < 2; v++) begin
         do_reset();
         seen_busy = 1'b0; seen_done = 1'b0;
         for (int t = 0; t < 15; t++) begin
            start = (t == 0); k_len = (v == 0) ? KW'(0) : KW'(K_MAX + 1);
            s_if.s_valid = 1'b1;
            sample();
            if (busy) seen_busy = 1'b1;
            if (done) seen_done = 1'b1;
            nxt();
         end
         check($sformatf("illegal%0d_busy", v), 64'(seen_busy), 0);
         check($sformatf("illegal%0d_done", v), 64'(seen_done), 0);
      end

      // ---- pe_en, k_len=1 (beat at cycle 1)
      do_reset();
      for (int t = 0; t < 13; t++) begin
         start = (t == 0); k_len = 1; s_if.s_valid = 1'b1;
         sample();
         pe_exp = '0;
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
               if (t == 2 + r + c || t == 7 + r) pe_exp[r*COLS+c] = 1'b1;
         check($sformatf("pe%0d", t), 64'(pe_en), 64'(pe_exp));
         nxt();
      end
      start = 1'b0; s_if.s_valid = 1'b0;

      // ---- reset mid-job: k_len=4, rst during 2nd beat (cycle 2)
      do_reset();
      seen_busy = 1'b0; seen_done = 1'b0;
      for (int t = 0; t < 26; t++) begin
         start = (t == 0); k_len = 4; s_if.s_valid = 1'b1;
         drive_beat(t, 3);
         rst = (t == 2);
         sample();
         if (t == 3) begin
            check("rstmid_ctrl", 64'({busy, done, s_if.s_ready}), 0);
            check("rstmid_en", 64'({mul_en, str_en, pe_en}), 0);
            check("rstmid_lanes", 64'({o_fmap, o_weight}), 0);
         end
         if (t >= 3 && busy) seen_busy = 1'b1;
         if (t >= 3 && done) seen_done = 1'b1;
         nxt();
      end
      rst = 1'b0; s_if.s_valid = 1'b0;
      check("rstmid_busy_after", 64'(seen_busy), 0);
      check("rstmid_no_done", 64'(seen_done), 0);

      // ---- back-to-back K_MAX jobs with golden matmul
      do_reset();
      run_job(K_MAX, 0, d1, f1, l1);
      check_matmul(K_MAX, 0, "job1");
      run_job(K_MAX, 9, d2, f2, l2);
      check_matmul(K_MAX, 9, "job2");
      check("job1_done_cycle", 64'(d1), 64'(K_MAX + ROWS + COLS));
      check("job2_done_cycle", 64'(d2), 64'(K_MAX + ROWS + COLS));
      check("job1_first_mul", 64'(f1), 64'd2);
      check("job2_first_mul", 64'(f2), 64'd2);
      check("job1_last_mul", 64'(l1), 64'(K_MAX + ROWS + COLS - 1));
      check("jobs_no_overlap", 64'(l1 < d1 + 1 + f2), 64'd1);
      sample();
      check("job2_busy_drop", 64'(busy), 0);
      nxt();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

- Upstream operand feeder and sequencer for the 5x5 systolic MAC array.
- Accepts one flat vector per reduction step k: ROWS fmap values plus COLS weight values, over a valid/ready handshake.
- Drives the array's west/north edges with diagonally skewed operands, and generates its mul_en / str_en / pe_en control buses.
- Runs one reduction of programmable length per start command, then signals done.

## Interface
- I_F_BW, 8, fmap element width
- W_BW, 8, weight element width
- ROWS, 5, array rows
- COLS, 5, array columns
- K_MAX, 16, maximum reduction length per job
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  start pulse; sampled only in IDLE
- k_len  in  $clog2(K_MAX+1)  steps in job, latched on start
- busy  out  1  high in FEED and DRAIN
- done  out  1  one-cycle pulse at job end
- s_valid  in  1  input beat valid
- s_ready  out  1  feeder accepts beat
- s_fmap  in  I_F_BW*ROWS  step-k fmap; row r at [(r+1)*I_F_BW-1 -: I_F_BW]
- s_weight  in  W_BW*COLS  step-k weights; col c at [(c+1)*W_BW-1 -: W_BW]
- o_fmap  out  I_F_BW*ROWS  skewed west-edge fmap to array
- o_weight  out  W_BW*COLS  skewed north-edge weights to array
- mul_en  out  ROWS+COLS-1  per-diagonal MAC enable; bit d covers PEs with r+c=d
- str_en  out  ROWS  per-row result store pulse
- pe_en  out  ROWS*COLS  per-PE clock-gate enable; bit r*COLS+c

## Operation
- FSM: IDLE -> FEED on start with 1<=k_len<=K_MAX; start with k_len==0 or k_len>K_MAX is ignored (remain IDLE, no done).
- FSM: FEED -> DRAIN on the cycle the k_len-th beat is accepted.
- FSM: DRAIN -> IDLE on the cycle str_en[ROWS-1] and done are asserted.
- start outside IDLE is ignored; k_len is not re-latched mid-job.
- s_ready = 1 only in FEED.
- Beat accepted when s_valid & s_ready; counter k_cnt increments; the beat whose acceptance makes k_cnt==k_len is tagged last.
- Bubbles (FEED, s_valid=0) enter the pipeline as invalid slots; no MAC is enabled for them.
- Skew line: row r fmap passes through r registers after the input stage; column c weight passes through c registers.
- Skew line has ROWS*(ROWS-1)/2 + COLS*(COLS-1)/2 element registers.
- Valid shift register vsr[0..ROWS+COLS-2]: vsr[0] = registered accept; vsr[d] = vsr[d-1] delayed one cycle.
- Last-tag shift register lsr shifts alongside vsr, with one extra stage.
- mul_en[d] = vsr[d].
- str_en[r] = lsr stage r+COLS-1 delayed one cycle: the cycle after row r's final MAC on PE(r,COLS-1).
- pe_en[r*COLS+c] = vsr[r+c] | str_en[r].
- done = str_en[ROWS-1].
- Invalid slots drive zero on o_fmap/o_weight lanes (see Configuration).

## Timing
- Reset: all outputs 0 (s_ready, busy, done, o_fmap, o_weight, mul_en, str_en, pe_en); state IDLE; k_cnt, vsr, lsr and skew registers cleared.
- Reset asserted mid-job aborts the job with no done pulse; the next cycle is IDLE.
- Beat accepted at cycle n:
  - o_fmap row 0 and o_weight col 0 carry it at n+1;
  - row r / col c carry it at n+1+r / n+1+c;
  - mul_en[d] high at n+1+d.
- Last beat accepted at cycle T: str_en[r] pulses at T+1+r+COLS; done at T+ROWS+COLS; busy drops at T+ROWS+COLS+1.
- Back-to-back job: start may be accepted the cycle after done, i.e. at T+ROWS+COLS+1; no overlap between jobs.
- k_len=1 is legal: a single beat, then DRAIN.
- Minimum job length with no bubbles: k_len + ROWS + COLS + 1 cycles from start to IDLE.

## Configuration
- SKEW_HOLD_EN defined: invalid slots do not load their skew lane; the lane holds its previous value, reducing toggle power. mul_en/pe_en are unchanged, so results are identical.
- SKEW_HOLD_EN undefined (default): invalid slots load zero into every skew lane.

## Test plan
- Single job, k_len=3, s_valid constant 1, fmap row r = 0x10+r, weight col c = 0x20+c, start at cycle 0:
  - beats accepted at cycles 1..3;
  - o_fmap row 4 = 0x14 at cycles 6..8;
  - str_en[0] at cycle 9, done at cycle 13;
  - array sums match a golden matmul.
- Bubble: k_len=2, s_valid low for 2 cycles between beats -> mul_en[0] shows a 2-cycle gap; lanes read zero in the gap (hold value under SKEW_HOLD_EN); done delayed exactly 2 cycles.
- Illegal start: k_len=0 -> busy stays 0, no done. Start while busy with k_len=7 -> ignored; first job completes with its original length.
- Reset mid-job: assert rst at the 2nd of 4 beats -> next cycle all outputs 0 and IDLE; no done.
- Back-to-back: k_len=K_MAX=16, new start the cycle after done -> second job timing identical to the first; no mul_en overlap between jobs.
- pe_en check, k_len=1: pe_en[r*COLS+c] high exactly at cycles 2+r+c and at the str_en[r] cycle; low otherwise.
